// File: rtl/monkey_dropper.sv
// Monkey placement controller: arms on a shop request, previews a ghost under the cursor,
// and commits on a fresh left-click at a legal, affordable spot. All outputs are registered.
module monkey_dropper #(
  parameter int COST    = 250,
  parameter int RADIUS  = 10,
  parameter int MAP_MAX = 479,
  parameter int PATH_Y0 = 220,
  parameter int PATH_Y1 = 260
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       mpready,
  input  logic [9:0] MouseX,
  input  logic [9:0] MouseY,
  input  logic [7:0] keycode,
  input  logic [9:0] money,
  output logic       placed,
  output logic [9:0] monkey_x,
  output logic [9:0] monkey_y,
  output logic       ghost_on,
  output logic       ghost_ok,
  output logic       debit
);

  localparam logic [10:0] EDGE_LO = 11'(RADIUS);
  localparam logic [10:0] EDGE_HI = 11'(MAP_MAX - RADIUS);
  localparam logic [10:0] BAND_LO = 11'((PATH_Y0 > RADIUS) ? (PATH_Y0 - RADIUS) : 0);
  localparam logic [10:0] BAND_HI = 11'(PATH_Y1 + RADIUS);
  localparam logic [10:0] COST_W  = 11'(COST);

  typedef enum logic [2:0] {IDLE, ARM, DRAG, COMMIT, PLACED} state_t;

  state_t      state_q, state_d;
  logic        click_prev_q;
  logic        placed_q, debit_q, ghost_on_q, ghost_ok_q;
  logic [9:0]  mon_x_q, mon_y_q;

  logic        click, press, pos_ok, funds_ok;
  logic [10:0] mx_w, my_w, money_w;

  assign mx_w    = {1'b0, MouseX};
  assign my_w    = {1'b0, MouseY};
  assign money_w = {1'b0, money};

  assign click    = (keycode == 8'h01);
  assign press    = click && !click_prev_q;
  assign funds_ok = (money_w >= COST_W);
  // Widened compares keep the band and edge limits free of wrap-around.
  assign pos_ok   = (mx_w >= EDGE_LO) && (mx_w <= EDGE_HI) &&
                    (my_w >= EDGE_LO) && (my_w <= EDGE_HI) &&
                    !((my_w >= BAND_LO) && (my_w <= BAND_HI));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mpready) state_d = ARM;
      ARM: begin
        // Wait for the shop's own click to be released before dragging.
        if (!mpready)    state_d = IDLE;
        else if (!click) state_d = DRAG;
      end
      DRAG: begin
        if (!mpready)                         state_d = IDLE;
        else if (press && pos_ok && funds_ok) state_d = COMMIT;
      end
      COMMIT:  state_d = PLACED;
      PLACED:  state_d = PLACED;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q      <= IDLE;
      click_prev_q <= 1'b0;
      placed_q     <= 1'b0;
      debit_q      <= 1'b0;
      ghost_on_q   <= 1'b0;
      ghost_ok_q   <= 1'b0;
      mon_x_q      <= '0;
      mon_y_q      <= '0;
    end else begin
      state_q      <= state_d;
      click_prev_q <= click;
      ghost_on_q   <= (state_d == DRAG);
      ghost_ok_q   <= (state_d == DRAG) && pos_ok && funds_ok;
      debit_q      <= (state_d == COMMIT);
      placed_q     <= (state_d == PLACED);
      // Tracks the cursor while dragging, including the committing edge, then holds.
      if (state_q == DRAG) begin
        mon_x_q <= MouseX;
        mon_y_q <= MouseY;
      end
    end
  end

  assign placed   = placed_q;
  assign debit    = debit_q;
  assign ghost_on = ghost_on_q;
  assign ghost_ok = ghost_ok_q;
  assign monkey_x = mon_x_q;
  assign monkey_y = mon_y_q;

endmodule

// File: tb/tb_monkey_dropper.sv
// Bench for monkey_dropper: directed scenarios plus random traffic, all scored against
// a behavioural placement model built from the default geometry and price.
module tb_monkey_dropper;

  logic       Clk = 1'b0;
  logic       reset, mpready;
  logic [9:0] MouseX, MouseY, money;
  logic [7:0] keycode;
  logic       placed, ghost_on, ghost_ok, debit;
  logic [9:0] monkey_x, monkey_y;

  int total = 0;
  int bad   = 0;

  monkey_dropper dut (
    .Clk(Clk), .reset(reset), .mpready(mpready), .MouseX(MouseX), .MouseY(MouseY),
    .keycode(keycode), .money(money), .placed(placed), .monkey_x(monkey_x),
    .monkey_y(monkey_y), .ghost_on(ghost_on), .ghost_ok(ghost_ok), .debit(debit)
  );

  always #5 Clk = ~Clk;

  // Model: what the player is doing, not how the controller encodes it.
  bit waiting_release, dragging, paying, done, btn_was_down;
  int ref_x, ref_y;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit spot_legal(input int x, input int y);
    bit on_map, on_path;
    on_map  = (x >= 10) && (x <= 469) && (y >= 10) && (y <= 469);
    on_path = (y >= 210) && (y <= 270);
    return on_map && !on_path;
  endfunction

  // Apply one cycle of inputs, advance the model across the edge, compare after the edge.
  task automatic cyc(input bit rst, input bit mp, input logic [7:0] key,
                     input int mx, input int my, input int cash);
    bit btn, fresh, legal, rich;
    bit was_drag;
    reset = rst; mpready = mp; keycode = key;
    MouseX = 10'(mx); MouseY = 10'(my); money = 10'(cash);
    @(posedge Clk);
    btn   = (key == 8'h01);
    fresh = btn && !btn_was_down;
    legal = spot_legal(mx, my);
    rich  = (cash >= 250);
    if (rst) begin
      waiting_release = 0; dragging = 0; paying = 0; done = 0; btn_was_down = 0;
      ref_x = 0; ref_y = 0;
    end else begin
      was_drag = dragging;
      if (done) begin
      end else if (paying) begin
        paying = 0; done = 1;
      end else if (dragging) begin
        if (!mp) dragging = 0;
        else if (fresh && legal && rich) begin dragging = 0; paying = 1; end
      end else if (waiting_release) begin
        if (!mp) waiting_release = 0;
        else if (!btn) begin waiting_release = 0; dragging = 1; end
      end else if (mp) begin
        waiting_release = 1;
      end
      if (was_drag) begin ref_x = mx; ref_y = my; end
      btn_was_down = btn;
    end
    #1;
    check("ghost_on", 32'(ghost_on), 32'(dragging));
    check("ghost_ok", 32'(ghost_ok), 32'(dragging && legal && rich));
    check("debit",    32'(debit),    32'(paying));
    check("placed",   32'(placed),   32'(done));
    check("monkey_x", 32'(monkey_x), 32'(ref_x));
    check("monkey_y", 32'(monkey_y), 32'(ref_y));
  endtask

  // Reset, then request and release so the controller is dragging.
  task automatic into_drag(input int cash);
    cyc(1, 0, 8'h00, 50, 50, cash);
    cyc(0, 1, 8'h01, 50, 50, cash);
    cyc(0, 1, 8'h00, 50, 50, cash);
  endtask

  // Release then press at (x,y); returns whether debit came up.
  task automatic try_press(input int x, input int y, input int cash, output bit paid);
    cyc(0, 1, 8'h00, x, y, cash);
    cyc(0, 1, 8'h01, x, y, cash);
    paid = debit;
  endtask

  int xs[14] = '{9, 10, 11, 209, 210, 270, 271, 468, 469, 470, 479, 480, 0, 1023};

  initial begin
    bit paid;
    logic [7:0] key;
    int mx, my, cash;

    // Reset with everything active, then idle with money but no request.
    cyc(1, 1, 8'h01, 100, 100, 300);
    check("rst_placed", 32'(placed), 32'd0);
    repeat (3) cyc(0, 0, 8'h00, 100, 100, 300);

    // Nominal: shop click held keeps ARM, release shows ghost, fresh press commits.
    repeat (3) cyc(0, 1, 8'h01, 100, 100, 300);
    check("arm_no_ghost", 32'(ghost_on), 32'd0);
    cyc(0, 1, 8'h00, 100, 100, 300);
    check("drag_ghost", 32'(ghost_on), 32'd1);
    cyc(0, 1, 8'h00, 100, 100, 300);
    cyc(0, 1, 8'h01, 100, 100, 300);
    check("nom_debit", 32'(debit), 32'd1);
    cyc(0, 0, 8'h00, 300, 20, 0);
    check("nom_placed", 32'(placed), 32'd1);
    repeat (4) cyc(0, 1, 8'h01, 300, 20, 0);
    check("nom_frozen_x", 32'(monkey_x), 32'd100);

    // Path band edges.
    into_drag(300);
    try_press(100, 230, 300, paid); check("path_230", 32'(paid), 32'd0);
    try_press(100, 270, 300, paid); check("path_270", 32'(paid), 32'd0);
    try_press(100, 271, 300, paid); check("path_271", 32'(paid), 32'd1);
    cyc(0, 1, 8'h00, 100, 271, 300);

    // Map edges.
    into_drag(300);
    try_press(9, 100, 300, paid);   check("x_9", 32'(paid), 32'd0);
    try_press(10, 100, 300, paid);  check("x_10", 32'(paid), 32'd1);
    into_drag(300);
    try_press(470, 100, 300, paid); check("x_470", 32'(paid), 32'd0);
    try_press(469, 100, 300, paid); check("x_469", 32'(paid), 32'd1);
    cyc(0, 1, 8'h00, 469, 100, 300);

    // Funds boundary.
    into_drag(249);
    try_press(100, 100, 249, paid); check("cash_249", 32'(paid), 32'd0);
    check("cash_249_ok", 32'(ghost_ok), 32'd0);
    try_press(100, 100, 250, paid); check("cash_250", 32'(paid), 32'd1);

    // Held button dragged onto a legal spot does not commit.
    into_drag(300);
    cyc(0, 1, 8'h01, 100, 230, 300);
    repeat (3) cyc(0, 1, 8'h01, 100, 100, 300);
    check("held_no_debit", 32'(debit), 32'd0);

    // Abort by dropping the request, then reset during COMMIT.
    cyc(0, 0, 8'h00, 100, 100, 300);
    check("abort_ghost", 32'(ghost_on), 32'd0);
    into_drag(300);
    try_press(100, 100, 300, paid);
    cyc(1, 1, 8'h01, 100, 100, 300);
    check("rst_commit_debit", 32'(debit), 32'd0);
    repeat (3) cyc(0, 0, 8'h00, 100, 100, 300);
    check("rst_commit_placed", 32'(placed), 32'd0);

    // Random traffic biased toward the interesting coordinates and prices.
    key = 8'h00;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 2) == 0)
        key = ($urandom_range(0, 9) == 0) ? 8'h03 : ((key == 8'h01) ? 8'h00 : 8'h01);
      mx = ($urandom_range(0, 1) == 0) ? xs[$urandom_range(0, 13)] : int'($urandom_range(0, 1023));
      my = ($urandom_range(0, 1) == 0) ? xs[$urandom_range(0, 13)] : int'($urandom_range(0, 1023));
      cash = ($urandom_range(0, 1) == 0) ? int'($urandom_range(249, 251)) : int'($urandom_range(0, 1023));
      cyc($urandom_range(0, 59) == 0, $urandom_range(0, 24) != 0, key, mx, my, cash);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
